flash_read_responder: RTL

//  Flash-side responder to the audio address calculator: accepts one word-read request (start_flash/read,
//  mem_addr, byteenable), runs one Avalon-MM pipelined read against the flash controller, returns the
//  32-bit word on audiodata and pulses end_flash_read. Sits between address_calc and the flash IP.
//  One read outstanding at a time; a watchdog bounds the wait for readdatavalid.

---
 rtl/flash_rd_pkg.sv | 20 ++
 rtl/flash_timeout_counter.sv | 50 +++++
 rtl/flash_read_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/flash_rd_pkg.sv
// ---------------------------------------------------------------------------
// flash_rd_pkg
// Shared types and default sizes for the flash read responder.
//   state_t         : responder FSM states
//   *_DEF constants : default word address width, data width and watchdog limit
// ---------------------------------------------------------------------------
package flash_rd_pkg;

    localparam int ADDR_W_DEF         = 23;
    localparam int DATA_W_DEF         = 32;
    localparam int TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/flash_timeout_counter.sv
// ---------------------------------------------------------------------------
// flash_timeout_counter
// Watchdog for the wait on read data. Counts up while enabled, saturates at
// TIMEOUT_CYCLES and never wraps. expire is high while the count sits on the
// last permitted wait cycle, so the owner aborts after exactly TIMEOUT_CYCLES
// enabled cycles.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   clear  in  return count to zero (wins over enable)
//   enable in  advance count by one
//   expire out count == TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module flash_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == CNT_LAST);

endmodule

// File: rtl/flash_read_responder.sv
// ---------------------------------------------------------------------------
// flash_read_responder
// Takes one word-read request from the audio address calculator, runs a single
// Avalon-MM pipelined read on the flash controller and hands the 32-bit word
// back on audiodata with a one-cycle end_flash_read pulse. One read is
// outstanding at a time; a watchdog bounds the wait for readdatavalid.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start_flash & read; request fields latched on accept
// ISSUE     | flash_mem_read high until the controller drops waitrequest
// WAIT_DATA | waiting for readdatavalid; watchdog running
// DONE      | end_flash_read pulse; watchdog cleared
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   start_flash, read           request strobe and qualifier
//   mem_addr, byteenable        request word address and byte lanes
//   audiodata                   captured read word (0 after a timeout)
//   end_flash_read              one-cycle completion pulse
//   busy                        high whenever not IDLE
//   timeout_err                 sticky watchdog-abort flag, cleared by reset only
//   flash_mem_*                 Avalon-MM master read interface
// ---------------------------------------------------------------------------
module flash_read_responder
    import flash_rd_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_flash,
    input  logic              read,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        byteenable,
    output logic [DATA_W-1:0] audiodata,
    output logic              end_flash_read,
    output logic              busy,
    output logic              timeout_err,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic [DATA_W-1:0] flash_mem_readdata,
    input  logic              flash_mem_readdatavalid
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              wd_clear;
    logic              wd_enable;
    logic              wd_expire;

    flash_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        data_d    = data_q;
        err_d     = err_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;

        unique case (state_q)
            IDLE: begin
                wd_clear = 1'b1;
                if (start_flash && read) begin
                    addr_d  = mem_addr;
                    be_d    = byteenable;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!flash_mem_waitrequest) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                wd_enable = 1'b1;
                // Data arriving on the last watchdog cycle still counts as success.
                if (flash_mem_readdatavalid) begin
                    data_d  = flash_mem_readdata;
                    state_d = DONE;
                end else if (wd_expire) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                wd_clear = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign audiodata            = data_q;
    assign timeout_err          = err_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = be_q;
    assign flash_mem_read       = (state_q == ISSUE);
    assign end_flash_read       = (state_q == DONE);
    assign busy                 = (state_q != IDLE);

endmodule
